// File: rtl/fir_pkg.sv
// Shared constants, default coefficient bank and FSM state type for the
// time-multiplexed FIR scheduler.
package fir_pkg;

    localparam int width = 32;
    localparam int order = 8;
    localparam int ACC_W = 2 * width + $clog2(order);

    localparam logic signed [31:0] FIR_COEFFS [order] = '{1, 2, 3, 4, 5, 6, 7, 8};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_sched_state_t;

    function automatic int fir_acc_width(input int w, input int o);
        return 2 * w + $clog2(o);
    endfunction

    // Instances with more taps than the default bank get zero-filled coefficients.
    function automatic logic signed [31:0] fir_default_coef(input int unsigned k);
        logic [$clog2(order)-1:0] idx;
        idx = k[$clog2(order)-1:0];
        return (k < order) ? FIR_COEFFS[idx] : '0;
    endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample store: writes land one past the current pointer, reads are
// addressed as "k samples back from the newest" with modulo-order wrap.
module fir_sample_ring #(
    parameter int width = 32,
    parameter int order = 8
) (
    input  logic                       clk_i,
    input  logic                       clear_i,
    input  logic                       wr_en_i,
    input  logic [width-1:0]           wr_data_i,
    input  logic [$clog2(order)-1:0]   rd_tap_i,
    output logic [width-1:0]           rd_data_o
);

    localparam int AW = $clog2(order);
    localparam logic [AW-1:0] LAST = AW'(order - 1);

    logic [width-1:0] buf_q [order];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_idx;

    assign wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;

    // Modulo-2^AW wrap of ptr+order-k is exact because the true index is < order.
    assign rd_idx = (wr_ptr_q >= rd_tap_i) ? (wr_ptr_q - rd_tap_i)
                                           : (wr_ptr_q + AW'(order) - rd_tap_i);
    assign rd_data_o = buf_q[rd_idx];

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            wr_ptr_q <= LAST;
            for (int unsigned i = 0; i < order; i++) begin
                buf_q[AW'(i)] <= '0;
            end
        end else if (wr_en_i) begin
            wr_ptr_q         <= wr_ptr_d;
            buf_q[wr_ptr_d]  <= wr_data_i;
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// FIR engine sequencing one shared multiply-accumulate across all taps per
// accepted sample, with a runtime-writable coefficient bank.
module fir_mac_scheduler #(
    parameter int width = fir_pkg::width,
    parameter int order = fir_pkg::order
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [width-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [width-1:0]           out_data,
    input  logic                       coef_we,
    input  logic [$clog2(order)-1:0]   coef_addr,
    input  logic [width-1:0]           coef_data,
    output logic                       coef_err,
    output logic                       busy
);

    import fir_pkg::*;

    localparam int AW     = $clog2(order);
    localparam int PW     = 2 * width;
    localparam int ACC_LW = fir_acc_width(width, order);
    localparam logic [AW-1:0] LAST_K = AW'(order - 1);

    fir_sched_state_t         state_q;
    logic [AW-1:0]            k_q;
    logic signed [ACC_LW-1:0] acc_q;
    logic signed [ACC_LW-1:0] acc_d;
    logic signed [width-1:0]  coef_q [order];
    logic                     out_valid_q;
    logic [width-1:0]         out_data_q;
    logic                     coef_err_q;

    logic [width-1:0]         tap_sample;
    logic signed [PW-1:0]     product;
    logic                     accept;
    logic                     addr_ok;

    if ((1 << AW) == order) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign addr_ok = (int'(coef_addr) < order);
    end

    assign accept = (state_q == IDLE) && in_valid;

    fir_sample_ring #(
        .width (width),
        .order (order)
    ) u_ring (
        .clk_i     (clk),
        .clear_i   (reset),
        .wr_en_i   (accept),
        .wr_data_i (in_data),
        .rd_tap_i  (k_q),
        .rd_data_o (tap_sample)
    );

    assign product = PW'(coef_q[k_q]) * PW'($signed(tap_sample));
    assign acc_d   = acc_q + ACC_LW'(product);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            coef_err_q  <= 1'b0;
            for (int unsigned i = 0; i < order; i++) begin
                coef_q[AW'(i)] <= width'(fir_default_coef(i));
            end
        end else begin
            coef_err_q <= 1'b0;
            // Coefficient update shares the accept edge, so MAC sees the new value.
            if (coef_we) begin
                if (state_q == IDLE && addr_ok) begin
                    coef_q[coef_addr] <= coef_data;
                end else begin
                    coef_err_q <= 1'b1;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (k_q == LAST_K) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_d[width-1:0];
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: order=4/width=16 main instance plus an
// order=5 instance for the out-of-range coefficient address case.
module tb_fir_mac_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_data;
    logic               coef_we = 1'b0;
    logic [1:0]         coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic               coef_err;
    logic               busy;

    logic               in_ready5;
    logic               out_valid5;
    logic [15:0]        out_data5;
    logic               coef_we5 = 1'b0;
    logic [2:0]         coef_addr5 = '0;
    logic               coef_err5;
    logic               busy5;

    int errors = 0;
    int checks = 0;

    fir_mac_scheduler #(.width(16), .order(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_err(coef_err), .busy(busy)
    );

    fir_mac_scheduler #(.width(16), .order(5)) dut5 (
        .clk(clk), .reset(reset),
        .in_valid(1'b0), .in_ready(in_ready5), .in_data(16'h0000),
        .out_valid(out_valid5), .out_ready(1'b1), .out_data(out_data5),
        .coef_we(coef_we5), .coef_addr(coef_addr5), .coef_data(16'h0007),
        .coef_err(coef_err5), .busy(busy5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Accepts one sample, waits (bounded) for out_valid, reports data and latency.
    task automatic run_sample(input logic signed [15:0] d,
                              output logic signed [15:0] q, output int lat);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        q = out_data;
        if (out_ready) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, out_valid, out_data, coef_err, busy} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h err=%b busy=%b want 1 0 0000 0 0",
                     in_ready, out_valid, out_data, coef_err, busy);
        end
        checks++;
        if ({in_ready5, out_valid5, out_data5, coef_err5, busy5} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state5: got rdy=%b vld=%b data=%h err=%b busy=%b want 1 0 0000 0 0",
                     in_ready5, out_valid5, out_data5, coef_err5, busy5);
        end
    endtask

    task automatic test_impulse();
        logic signed [15:0] ins [5] = '{16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        logic signed [15:0] exp [5] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0};
        logic signed [15:0] q;
        int lat;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_sample(ins[i], q, lat);
            checks++;
            if (q !== exp[i]) begin
                errors++;
                $display("FAIL impulse_data[%0d]: got %0d want %0d", i, q, exp[i]);
            end
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL impulse_latency[%0d]: got %0d want 4", i, lat);
            end
        end
    endtask

    task automatic test_step();
        logic signed [15:0] exp [5] = '{16'sd10, 16'sd30, 16'sd60, 16'sd100, 16'sd100};
        logic signed [15:0] q;
        int lat;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_sample(16'sd10, q, lat);
            checks++;
            if (q !== exp[i]) begin
                errors++;
                $display("FAIL step_data[%0d]: got %0d want %0d", i, q, exp[i]);
            end
        end
        do_reset();
        run_sample(-16'sd5, q, lat);
        checks++;
        if (q !== -16'sd5) begin
            errors++;
            $display("FAIL signed_input: got %0d want -5", q);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'sd5;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({out_valid, out_data, in_ready, busy} !== {1'b1, 16'h0005, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL hold[%0d]: got vld=%b data=%h rdy=%b busy=%b want 1 0005 0 1",
                         i, out_valid, out_data, in_ready, busy);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_transfer: got vld=%b want 0", out_valid);
        end
    endtask

    task automatic test_coef_write();
        logic signed [15:0] exp [4] = '{16'sd1, 16'sd2, -16'sd1, 16'sd4};
        logic signed [15:0] q;
        int lat;
        do_reset();
        coef_we = 1'b1; coef_addr = 2'd2; coef_data = -16'sd1;
        tick();
        coef_we = 1'b0;
        checks++;
        if (coef_err !== 1'b0) begin
            errors++;
            $display("FAIL coef_idle_err: got %b want 0", coef_err);
        end
        for (int i = 0; i < 4; i++) begin
            run_sample((i == 0) ? 16'sd1 : 16'sd0, q, lat);
            checks++;
            if (q !== exp[i]) begin
                errors++;
                $display("FAIL coef_impulse[%0d]: got %0d want %0d", i, q, exp[i]);
            end
        end

        // Write attempted while the MAC is running must be dropped and flagged.
        do_reset();
        in_valid = 1'b1; in_data = 16'sd1;
        tick();
        in_valid = 1'b0;
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'sd100;
        tick();
        coef_we = 1'b0;
        checks++;
        if (coef_err !== 1'b1) begin
            errors++;
            $display("FAIL coef_mac_err_pulse: got %b want 1", coef_err);
        end
        tick();
        checks++;
        if (coef_err !== 1'b0) begin
            errors++;
            $display("FAIL coef_mac_err_clear: got %b want 0", coef_err);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if ({out_valid, out_data} !== {1'b1, 16'h0001}) begin
            errors++;
            $display("FAIL coef_mac_ignored: got vld=%b data=%0d want 1 1", out_valid, out_data);
        end
        tick();
        run_sample(16'sd0, q, lat);
        run_sample(16'sd0, q, lat);
        run_sample(16'sd0, q, lat);
        run_sample(16'sd1, q, lat);
        checks++;
        if (q !== 16'sd1) begin
            errors++;
            $display("FAIL coef0_unchanged: got %0d want 1", q);
        end

        coef_we5 = 1'b1; coef_addr5 = 3'd6;
        tick();
        coef_we5 = 1'b0;
        checks++;
        if (coef_err5 !== 1'b1) begin
            errors++;
            $display("FAIL coef_range_err: got %b want 1", coef_err5);
        end
        coef_we5 = 1'b1; coef_addr5 = 3'd4;
        tick();
        coef_we5 = 1'b0;
        checks++;
        if (coef_err5 !== 1'b0) begin
            errors++;
            $display("FAIL coef_last_addr_ok: got %b want 0", coef_err5);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [15:0] exp [4] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        logic signed [15:0] q;
        int lat;
        int seen;
        do_reset();
        coef_we = 1'b1; coef_addr = 2'd1; coef_data = 16'sd9;
        tick();
        coef_we = 1'b0;
        in_valid = 1'b1; in_data = 16'sd7;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL abort_state: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_output: got %0d outputs want 0", seen);
        end
        for (int i = 0; i < 4; i++) begin
            run_sample((i == 0) ? 16'sd1 : 16'sd0, q, lat);
            checks++;
            if (q !== exp[i]) begin
                errors++;
                $display("FAIL post_reset_impulse[%0d]: got %0d want %0d", i, q, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic signed [15:0] cf [4] = '{16'sh7FFF, 16'sh7FFF, 16'sh0000, 16'sh0000};
        logic signed [15:0] q;
        int lat;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            coef_we = 1'b1; coef_addr = 2'(i); coef_data = cf[i];
            tick();
        end
        coef_we = 1'b0;
        run_sample(16'sh7FFF, q, lat);
        checks++;
        if (q !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_first: got %h want 0001", q);
        end
        run_sample(16'sh7FFF, q, lat);
        checks++;
        if (q !== 16'h0002) begin
            errors++;
            $display("FAIL wrap_second: got %h want 0002", q);
        end
    endtask

    task automatic test_back_to_back();
        int acc_c [8];
        logic signed [15:0] outs [8];
        int na;
        int no;
        logic pre;
        logic signed [15:0] exp [3] = '{16'sd3, 16'sd9, 16'sd18};
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'sd3;
        na = 0;
        no = 0;
        for (int c = 0; c < 20; c++) begin
            pre = in_ready;
            tick();
            if (pre && na < 8) begin
                acc_c[na] = c;
                na++;
            end
            if (out_valid && no < 8) begin
                outs[no] = out_data;
                no++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (na < 2 || (acc_c[1] - acc_c[0]) !== 6) begin
            errors++;
            $display("FAIL b2b_period: got %0d accepts gap %0d want gap 6", na,
                     (na < 2) ? -1 : acc_c[1] - acc_c[0]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (no <= i || outs[i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %0d (count %0d) want %0d", i,
                         (no > i) ? outs[i] : 16'sd0, no, exp[i]);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_backpressure();
        test_coef_write();
        test_reset_mid_mac();
        test_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
